// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch PC with prioritised trap / redirect / return
// selection, target alignment masking and a circular return-address stack.
module pc_sequencer #(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     STEP         = 4,
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         trap_valid,
  input  logic [XLEN-1:0]              trap_vector,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_target,
  input  logic                         redirect_is_call,
  input  logic                         ret_valid,
  input  logic [XLEN-1:0]              ret_fallback,
  output logic [XLEN-1:0]              pc_out,
  output logic                         redirected,
  output logic                         target_misaligned,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  // Low target bits that must be zero; an all-zero mask disables the check.
  localparam logic [XLEN-1:0] ALIGN_MASK =
    (ALIGN_BITS == 0) ? '0 : ({XLEN{1'b1}} >> (XLEN - ALIGN_BITS));

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_HOLD,
    SRC_TRAP,
    SRC_REDIRECT,
    SRC_RETURN
  } src_e;

  src_e             src;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;
  logic [XLEN-1:0]  pc_seq;
  logic [XLEN-1:0]  raw_target;
  logic [XLEN-1:0]  pc_next;
  logic             ras_hit;
  logic             push;
  logic             pop;
  logic             redir_next;
  logic             mis_next;

  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));

  // Fixed-priority choice of where the next PC comes from.
  always_comb begin
    src = SRC_SEQ;
    if (trap_valid)                src = SRC_TRAP;
    else if (redirect_valid)       src = SRC_REDIRECT;
    else if (ret_valid && !stall)  src = SRC_RETURN;
    else if (stall)                src = SRC_HOLD;
  end

  // Next-PC datapath: target mux, alignment masking and RAS push/pop strobes.
  always_comb begin
    ras_hit    = !ras_empty;
    pc_seq     = pc_out + XLEN'(STEP);
    top_inc    = top_ptr + PTR_W'(1);
    top_dec    = top_ptr - PTR_W'(1);
    push       = (src == SRC_REDIRECT) && redirect_is_call;
    pop        = (src == SRC_RETURN) && ras_hit;
    raw_target = '0;
    redir_next = 1'b1;
    unique case (src)
      SRC_TRAP:     raw_target = trap_vector;
      SRC_REDIRECT: raw_target = redirect_target;
      SRC_RETURN:   raw_target = ras_hit ? ras_mem[top_ptr] : ret_fallback;
      default:      redir_next = 1'b0;
    endcase
    mis_next = redir_next && ((raw_target & ALIGN_MASK) != '0);
    unique case (src)
      SRC_SEQ:  pc_next = pc_seq;
      SRC_HOLD: pc_next = pc_out;
      default:  pc_next = raw_target & ~ALIGN_MASK;
    endcase
  end

  // PC, status flags and RAS bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out            <= RESET_VECTOR;
      redirected        <= 1'b0;
      target_misaligned <= 1'b0;
      ras_count         <= '0;
      top_ptr           <= '0;
    end else begin
      pc_out            <= pc_next;
      redirected        <= redir_next;
      target_misaligned <= mis_next;
      if (push) begin
        top_ptr <= top_inc;
        if (!ras_full) ras_count <= ras_count + CNT_W'(1);
      end else if (pop) begin
        top_ptr   <= top_dec;
        ras_count <= ras_count - CNT_W'(1);
      end
    end
  end

  // RAS storage; a push at full count overwrites the oldest slot via wraparound.
  always_ff @(posedge clk) begin
    if (push) ras_mem[top_inc] <= pc_seq;
  end

endmodule
